irq_prioritizer: RTL

Interrupt front end for the processor's address sequencer. Synchronises seven peripheral request lines, holds them as pending, masks and prioritises them, and presents one 3-bit vector code on `irq1`/`irq2`/`irq3`. The sequencer vectors on a non-zero code and jumps to address code+1. The code is held stable until the sequencer reports it was taken, then withheld until the sequencer's in-service flag clears.

---
 rtl/irq_prioritizer_if.sv | 24 ++
 rtl/irq_prioritizer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/irq_prioritizer_if.sv
// Sequencer-facing bundle of the interrupt front end: raw requests, sequencer
// handshake, register port and the 3-bit vector code.
interface irq_prioritizer_if;
  logic [6:0]  src;
  logic        take;
  logic        inter;
  logic [1:0]  addr;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq1;
  logic        irq2;
  logic        irq3;

  modport master (
    output src, take, inter, addr, wr, wdata,
    input  rdata, irq1, irq2, irq3
  );

  modport slave (
    input  src, take, inter, addr, wr, wdata,
    output rdata, irq1, irq2, irq3
  );
endinterface

// File: rtl/irq_prioritizer.sv
// Interrupt front end: synchronises seven request lines, keeps them pending,
// masks and prioritises them and presents one held vector code to the sequencer.
module irq_prioritizer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] SRC_EDGE    = 7'h7F
) (
  input  logic         clk,
  input  logic         rst,
  irq_prioritizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  code, code_nxt;
  logic [1:0]  svc_cnt, svc_cnt_nxt;

  logic [6:0]  sync_p [SYNC_STAGES];
  logic [6:0]  synced, synced_prev;
  logic [6:0]  mask, pend_edge, lost;
  logic [6:0]  rise, pend, cand, sel_bit;
  logic [6:0]  take_clr, sw_clr, lost_clr, pend_clr;
  logic [2:0]  win;
  logic        take_fire, wr_mask;
  logic [15:0] rdata;
  logic        unused_wdata;

  assign unused_wdata = ^bus.wdata[15:7];

  // Synchroniser output and edge detection
  assign synced = sync_p[SYNC_STAGES-1];
  assign rise   = synced & ~synced_prev & SRC_EDGE;

  // Level sources track the synchronised line directly; edge sources are latched
  assign pend = (pend_edge & SRC_EDGE) | (synced & ~SRC_EDGE);
  assign cand = pend & mask;

  assign sel_bit   = 7'd1 << (code - 3'd1);
  assign take_fire = (state == PRESENT) && bus.take;
  assign take_clr  = take_fire ? (sel_bit & SRC_EDGE) : 7'd0;
  assign wr_mask   = bus.wr && (bus.addr == 2'd0);
  assign sw_clr    = (bus.wr && (bus.addr == 2'd1)) ? (bus.wdata[6:0] & SRC_EDGE) : 7'd0;
  assign lost_clr  = (bus.wr && (bus.addr == 2'd3)) ? bus.wdata[6:0] : 7'd0;
  assign pend_clr  = take_clr | sw_clr;

  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (cand[i]) win = 3'(i + 1);
    end
  end

  always_comb begin
    state_nxt   = state;
    code_nxt    = code;
    svc_cnt_nxt = svc_cnt;
    case (state)
      IDLE: begin
        if ((cand != 7'd0) && !bus.inter) begin
          code_nxt  = win;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.take) begin
          code_nxt    = 3'd0;
          state_nxt   = SERVICE;
          svc_cnt_nxt = 2'd0;
        end else if ((cand & sel_bit) == 7'd0) begin
          code_nxt  = 3'd0;
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        // First SERVICE cycle ignores inter: the sequencer's flag is registered
        if ((svc_cnt != 2'd0) && !bus.inter) begin
          state_nxt = IDLE;
        end else if (svc_cnt != 2'd3) begin
          svc_cnt_nxt = svc_cnt + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = 3'd0;
      end
    endcase
  end

  // Registered state: synchronisers, registers, FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= 7'd0;
      synced_prev <= 7'd0;
      mask        <= 7'd0;
      pend_edge   <= 7'd0;
      lost        <= 7'd0;
      state       <= IDLE;
      code        <= 3'd0;
      svc_cnt     <= 2'd0;
    end else begin
      sync_p[0] <= bus.src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      synced_prev <= synced;
      if (wr_mask) mask <= bus.wdata[6:0];
      // A new edge wins over any clear in the same cycle and is then not lost
      pend_edge <= rise | (pend_edge & ~pend_clr);
      lost      <= (lost & ~lost_clr) | (rise & pend_edge & ~pend_clr);
      state     <= state_nxt;
      code      <= code_nxt;
      svc_cnt   <= svc_cnt_nxt;
    end
  end

  always_comb begin
    rdata = 16'd0;
    case (bus.addr)
      2'd0:    rdata[6:0] = mask;
      2'd1:    rdata[6:0] = pend;
      2'd2:    rdata[4:0] = {state, code};
      default: rdata[6:0] = lost;
    endcase
  end

  assign bus.rdata = rdata;
  assign bus.irq1  = code[0];
  assign bus.irq2  = code[1];
  assign bus.irq3  = code[2];

endmodule
